// File: rtl/pc_sequencer_if.sv
// ============================================================================
// Module      : pc_sequencer_if
// Description : Decode-side command bus and sequencer status bus for the
//               ez8 fetch-stage program-counter sequencer.
//               master : decode stage (drives commands, observes status)
//               slave  : pc_sequencer (consumes commands, drives status)
//               Signals: pause, goto, goto_addr, call, skip, ret (commands);
//               pc_out, kill, stopped, error, stack_level (status).
//               With PC_SEQ_IRQ_EN defined the bus also carries irq, reti
//               (commands) and irq_ack, in_isr (status).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_sequencer_if #(
    parameter int ADDR_WIDTH  = 12,
    parameter int STACK_DEPTH = 16
) ();
    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1);

    logic                   pause;
    logic                   goto;
    logic [ADDR_WIDTH-1:0]  goto_addr;
    logic                   call;
    logic                   skip;
    logic                   ret;
    logic [ADDR_WIDTH-1:0]  pc_out;
    logic                   kill;
    logic                   stopped;
    logic                   error;
    logic [LEVEL_WIDTH-1:0] stack_level;
`ifdef PC_SEQ_IRQ_EN
    logic                   irq;
    logic                   reti;
    logic                   irq_ack;
    logic                   in_isr;
`endif

    modport master (
`ifdef PC_SEQ_IRQ_EN
        output irq, reti,
        input  irq_ack, in_isr,
`endif
        output pause, goto, goto_addr, call, skip, ret,
        input  pc_out, kill, stopped, error, stack_level
    );

    modport slave (
`ifdef PC_SEQ_IRQ_EN
        input  irq, reti,
        output irq_ack, in_isr,
`endif
        input  pause, goto, goto_addr, call, skip, ret,
        output pc_out, kill, stopped, error, stack_level
    );
endinterface

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for the ez8 fetch stage. One action
//               per cycle (skip > goto/call > ret > increment), an internal
//               LIFO return stack and a KILL_DEPTH-deep kill shift register
//               that squashes instructions already in flight after a change
//               of flow.
//               Ports: clk, reset_n (synchronous, active low), bus
//               (pc_sequencer_if.slave: commands in, pc/kill/status out).
//               Optional feature macro: PC_SEQ_IRQ_EN adds single-level
//               interrupt entry (irq -> IRQ_VECTOR) and reti.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    STACK_DEPTH = 16,
    parameter int                    KILL_DEPTH  = 2,
    parameter logic [ADDR_WIDTH-1:0] IRQ_VECTOR  = 'h004
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    pc_sequencer_if.slave    bus
);
    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH + 1);
    localparam int IDX_WIDTH   = $clog2(STACK_DEPTH);
    localparam logic [KILL_DEPTH-1:0]  KILL_SKIP = KILL_DEPTH'(1) << (KILL_DEPTH - 1);
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX = LEVEL_WIDTH'(STACK_DEPTH);

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [KILL_DEPTH-1:0]  r_kill_sr;
    logic                   r_stopped;
    logic                   r_error;
    logic                   r_in_isr;
    logic [LEVEL_WIDTH-1:0] r_level;
    logic [ADDR_WIDTH-1:0]  r_stack [STACK_DEPTH];

    logic                   w_irq_req;
    logic                   w_reti;
    logic                   w_hold;
    logic                   w_kill;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_do_skip;
    logic                   w_ret_any;
    logic                   w_do_call;
    logic                   w_do_pop;
    logic                   w_do_irq;
    logic                   w_push;
    logic [ADDR_WIDTH-1:0]  w_pc_inc;
    logic [ADDR_WIDTH-1:0]  w_push_data;
    logic [ADDR_WIDTH-1:0]  w_top;
    logic [IDX_WIDTH-1:0]   w_push_idx;
    logic [IDX_WIDTH-1:0]   w_top_idx;
    logic [KILL_DEPTH-1:0]  w_kill_shift0;
    logic [KILL_DEPTH-1:0]  w_kill_shift1;

`ifdef PC_SEQ_IRQ_EN
    assign w_irq_req = bus.irq;
    assign w_reti    = bus.reti;
`else
    // Interrupt path tied off; the shared control logic reduces away.
    assign w_irq_req = 1'b0;
    assign w_reti    = 1'b0;
`endif

    assign w_hold    = bus.pause | r_stopped;
    assign w_kill    = r_kill_sr[KILL_DEPTH-1];
    assign w_full    = (r_level == LEVEL_MAX);
    assign w_empty   = (r_level == '0);
    assign w_pc_inc  = r_pc + ADDR_WIDTH'(1);

    // A left shift of a one-bit register is a plain load of the new bit,
    // so the same expressions cover KILL_DEPTH=1.
    assign w_kill_shift0 = r_kill_sr << 1;
    assign w_kill_shift1 = (r_kill_sr << 1) | KILL_DEPTH'(1);

    // Skip while kill is already asserted falls through to lower priorities.
    assign w_do_skip = bus.skip & ~w_kill;
    assign w_ret_any = bus.ret | w_reti;
    assign w_do_call = ~w_hold & ~w_do_skip & bus.goto & bus.call & ~w_full;
    assign w_do_pop  = ~w_hold & ~w_do_skip & ~bus.goto & w_ret_any & ~w_empty;
    assign w_do_irq  = ~w_hold & ~w_do_skip & ~bus.goto & ~w_ret_any
                     & w_irq_req & ~r_in_isr & ~w_full;
    assign w_push    = w_do_call | w_do_irq;

    // A call returns past itself (pc+1); an interrupt resumes the address it
    // pre-empted, since that instruction was never fetched.
    assign w_push_data = w_do_irq ? r_pc : w_pc_inc;
    assign w_push_idx  = IDX_WIDTH'(r_level);
    assign w_top_idx   = IDX_WIDTH'(r_level - LEVEL_WIDTH'(1));
    assign w_top       = r_stack[w_top_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc      <= '0;
            r_kill_sr <= '1;
            r_stopped <= 1'b0;
            r_error   <= 1'b0;
            r_in_isr  <= 1'b0;
            r_level   <= '0;
        end else if (!w_hold) begin
            if (w_do_skip) begin
                r_kill_sr <= KILL_SKIP;
            end else if (bus.goto) begin
                if (bus.call && w_full) begin
                    r_stopped <= 1'b1;
                    r_error   <= 1'b1;
                end else begin
                    r_pc      <= bus.goto_addr;
                    r_kill_sr <= w_kill_shift1;
                    if (bus.call) begin
                        r_level <= r_level + LEVEL_WIDTH'(1);
                    end
                end
            end else if (w_ret_any) begin
                if (w_empty) begin
                    // Plain ret on an empty stack is the normal program exit;
                    // reti on an empty stack is a fault.
                    r_stopped <= 1'b1;
                    r_error   <= w_reti;
                end else begin
                    r_pc      <= w_top;
                    r_kill_sr <= w_kill_shift1;
                    r_level   <= r_level - LEVEL_WIDTH'(1);
                    if (w_reti) begin
                        r_in_isr <= 1'b0;
                    end
                end
            end else if (w_do_irq) begin
                r_pc      <= IRQ_VECTOR;
                r_kill_sr <= w_kill_shift1;
                r_level   <= r_level + LEVEL_WIDTH'(1);
                r_in_isr  <= 1'b1;
            end else begin
                r_pc      <= w_pc_inc;
                r_kill_sr <= w_kill_shift0;
            end
        end
    end

    // Stack storage carries no reset: entries above the level are don't-care.
    always_ff @(posedge clk) begin
        if (reset_n && w_push) begin
            r_stack[w_push_idx] <= w_push_data;
        end
    end

`ifdef PC_SEQ_IRQ_EN
    logic r_irq_ack;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_ack <= 1'b0;
        end else begin
            r_irq_ack <= w_do_irq;
        end
    end

    assign bus.irq_ack = r_irq_ack;
    assign bus.in_isr  = r_in_isr;
`endif

    assign bus.pc_out      = r_pc;
    assign bus.kill        = w_kill;
    assign bus.stopped     = r_stopped;
    assign bus.error       = r_error;
    assign bus.stack_level = r_level;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer (STACK_DEPTH=4,
//               KILL_DEPTH=2). Directed scenarios followed by randomized
//               command streams, compared every cycle against a behavioural
//               model built from a PC integer, a queue-based return stack and
//               a queue of pending kill bits. Interrupt inputs are held low
//               when PC_SEQ_IRQ_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
    localparam int AW = 12;
    localparam int SD = 4;
    localparam int KD = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_WIDTH(AW), .STACK_DEPTH(SD)) bus_if ();

    pc_sequencer #(
        .ADDR_WIDTH (AW),
        .STACK_DEPTH(SD),
        .KILL_DEPTH (KD),
        .IRQ_VECTOR (12'h004)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus_if)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_kill[$];      // index 0 = instruction now at issue (oldest)
    bit m_stopped;
    bit m_error;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic kill_advance(input bit b);
        void'(m_kill.pop_front());
        m_kill.push_back(b);
    endtask

    task automatic model_step(input bit rn, input bit pz, input bit gt, input bit cl,
                              input bit sk, input bit rt, input int addr);
        if (!rn) begin
            m_pc = 0;
            m_stack.delete();
            m_kill.delete();
            for (int i = 0; i < KD; i++) m_kill.push_back(1'b1);
            m_stopped = 1'b0;
            m_error   = 1'b0;
        end else if (pz || m_stopped) begin
            // frozen
        end else if (sk && !m_kill[0]) begin
            for (int i = 0; i < KD; i++) m_kill[i] = (i == 0);
        end else if (gt) begin
            if (cl && m_stack.size() == SD) begin
                m_stopped = 1'b1;
                m_error   = 1'b1;
            end else begin
                if (cl) m_stack.push_back((m_pc + 1) % (1 << AW));
                m_pc = addr;
                kill_advance(1'b1);
            end
        end else if (rt) begin
            if (m_stack.size() == 0) begin
                m_stopped = 1'b1;
            end else begin
                m_pc = m_stack.pop_back();
                kill_advance(1'b1);
            end
        end else begin
            m_pc = (m_pc + 1) % (1 << AW);
            kill_advance(1'b0);
        end
    endtask

    task automatic compare_all();
        check("pc",      32'(bus_if.pc_out),      32'(m_pc));
        check("kill",    32'(bus_if.kill),        32'(m_kill[0]));
        check("stopped", 32'(bus_if.stopped),     32'(m_stopped));
        check("error",   32'(bus_if.error),       32'(m_error));
        check("level",   32'(bus_if.stack_level), 32'(m_stack.size()));
    endtask

    task automatic cycle(input bit rn, input bit pz, input bit gt, input bit cl,
                         input bit sk, input bit rt, input int addr);
        reset_n             = rn;
        bus_if.pause        = pz;
        bus_if.goto         = gt;
        bus_if.call         = cl;
        bus_if.skip         = sk;
        bus_if.ret          = rt;
        bus_if.goto_addr    = AW'(addr);
`ifdef PC_SEQ_IRQ_EN
        bus_if.irq          = 1'b0;
        bus_if.reti         = 1'b0;
`endif
        @(posedge clk);
        model_step(rn, pz, gt, cl, sk, rt, addr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();          cycle(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic idle();              cycle(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_goto(input int a); cycle(1, 0, 1, 0, 0, 0, a); endtask
    task automatic do_call(input int a); cycle(1, 0, 1, 1, 0, 0, a); endtask
    task automatic do_ret();            cycle(1, 0, 0, 0, 0, 1, 0); endtask
    task automatic do_skip();           cycle(1, 0, 0, 0, 1, 0, 0); endtask

    initial begin
        // 1: reset then free-running increment
        do_reset(); do_reset();
        check("t1_pc_rst", 32'(bus_if.pc_out), 32'h0);
        check("t1_kill_rst", 32'(bus_if.kill), 32'h1);
        idle();
        check("t1_pc1", 32'(bus_if.pc_out), 32'h1);
        check("t1_kill1", 32'(bus_if.kill), 32'h1);
        idle();
        check("t1_pc2", 32'(bus_if.pc_out), 32'h2);
        check("t1_kill2", 32'(bus_if.kill), 32'h0);

        // 2: call and return
        do_goto(12'h010);
        do_call(12'h200);
        check("t2_pc", 32'(bus_if.pc_out), 32'h200);
        check("t2_level", 32'(bus_if.stack_level), 32'h1);
        check("t2_kill_a", 32'(bus_if.kill), 32'h1);
        idle();
        check("t2_kill_b", 32'(bus_if.kill), 32'h1);
        idle();
        check("t2_kill_c", 32'(bus_if.kill), 32'h0);
        do_ret();
        check("t2_ret_pc", 32'(bus_if.pc_out), 32'h011);
        check("t2_ret_level", 32'(bus_if.stack_level), 32'h0);

        // 3: overflow on the fifth nested call
        do_reset();
        for (int i = 1; i <= 5; i++) do_call(i * 12'h100);
        check("t3_stopped", 32'(bus_if.stopped), 32'h1);
        check("t3_error", 32'(bus_if.error), 32'h1);
        check("t3_pc", 32'(bus_if.pc_out), 32'h400);
        check("t3_level", 32'(bus_if.stack_level), 32'h4);
        idle();
        check("t3_pc_hold", 32'(bus_if.pc_out), 32'h400);

        // 4: ret on empty stack is a clean stop
        do_reset();
        do_ret();
        check("t4_stopped", 32'(bus_if.stopped), 32'h1);
        check("t4_error", 32'(bus_if.error), 32'h0);
        do_goto(12'h123);
        idle();
        check("t4_pc_hold", 32'(bus_if.pc_out), 32'h0);
        do_reset();
        check("t4_unstop", 32'(bus_if.stopped), 32'h0);

        // 5: skip behaviour
        do_goto(12'h02E);
        idle(); idle();
        check("t5_pc_pre", 32'(bus_if.pc_out), 32'h030);
        check("t5_kill_pre", 32'(bus_if.kill), 32'h0);
        do_skip();
        check("t5_pc_skip", 32'(bus_if.pc_out), 32'h030);
        check("t5_kill_skip", 32'(bus_if.kill), 32'h1);
        idle();
        check("t5_kill_after", 32'(bus_if.kill), 32'h0);
        check("t5_pc_after", 32'(bus_if.pc_out), 32'h031);
        cycle(1, 0, 1, 0, 1, 0, 12'h300);
        check("t5_skip_wins", 32'(bus_if.pc_out), 32'h031);
        cycle(1, 0, 1, 0, 1, 0, 12'h300);
        check("t5_skip_ignored", 32'(bus_if.pc_out), 32'h300);

        // 6: pause, wrap, reset mid call chain
        do_reset(); idle(); idle();
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 1, 0, 0, 0, 12'h222);
            check("t6_pause_pc", 32'(bus_if.pc_out), 32'h2);
            check("t6_pause_kill", 32'(bus_if.kill), 32'h0);
        end
        do_goto(12'hFFF);
        idle();
        check("t6_wrap", 32'(bus_if.pc_out), 32'h000);
        do_call(12'h100); do_call(12'h200);
        do_reset();
        check("t6_rst_level", 32'(bus_if.stack_level), 32'h0);
        check("t6_rst_pc", 32'(bus_if.pc_out), 32'h0);

        // Randomized command streams
        for (int n = 0; n < 3000; n++) begin
            bit rn, pz, gt, cl, sk, rt;
            rn = m_stopped ? ($urandom_range(0, 99) >= 20) : ($urandom_range(0, 99) >= 2);
            pz = ($urandom_range(0, 9) == 0);
            gt = ($urandom_range(0, 5) == 0);
            cl = 1'($urandom_range(0, 1));
            sk = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 6) == 0);
            cycle(rn, pz, gt, cl, sk, rt, int'($urandom_range(0, 4095)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
